data_mem_ctrl: RTL

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//
// Single-port word-addressed data memory behind a shared bidirectional bus.
// The master drives dbus with write data; the block drives dbus with read data
// only during the single response cycle (rvalid=1). At all other times the bus
// is left high-impedance.
//
// Writes complete in the accept cycle and keep ready high, so writes can
// be issued back-to-back. Reads take exactly READ_LAT cycles from accept to
// response. While a read is in flight ready is low and en is ignored.
//
// Optional build macro:
//   DMEM_RANGE_CHK_EN - flags accepted requests whose address is >= DEPTH.
//                       These requests set the sticky err output,
//                       suppress the write, and return 0 for reads.
//                       Without the macro, upper address bits are ignored
//                       and err is tied low.
//
// Parameters:
//   DATA_W   - data/bus width in bits (multiple of 8)
//   ADDR_W   - address port width (expected >= log2(DEPTH))
//   DEPTH    - number of DATA_W words (power of two)
//   READ_LAT - read accept-to-response latency in cycles (1..4)
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   addr   - word address
//   en     - request strobe
//   we     - 1 = write, 0 = read (sampled with en)
//   be     - byte enables for writes, bit i gates byte i
//   dbus   - shared data bus (inout)
//   ready  - high while a request can be accepted (IDLE only)
//   rvalid - high for the one cycle dbus carries read data
//   err    - sticky out-of-range flag
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 4096,
    parameter int READ_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                en,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    inout  wire  [DATA_W-1:0]   dbus,
    output logic                ready,
    output logic                rvalid,
    output logic                err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int BE_W  = DATA_W / 8;

    // Cycles spent in WAIT before RESP: READ_LAT-1 in total. The countdown
    // starts at READ_LAT-2 because the terminal-count cycle is itself a WAIT
    // cycle.
    localparam logic [1:0] CNT_INIT = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        cnt_p0;
    logic [1:0]        cnt_nxt;
    logic [DATA_W-1:0] rdata_p1;
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              oor;

    logic [DATA_W-1:0] mem [DEPTH];

    assign idx    = addr[IDX_W-1:0];
    assign ready  = (state == IDLE);
    assign rvalid = (state == RESP);

    // en in a reset cycle must not reach the memory or the read capture.
    assign accept = en && ready && !rst;

`ifdef DMEM_RANGE_CHK_EN
    logic err_q;

    generate
        if (ADDR_W > IDX_W) begin : g_oor
            assign oor = |addr[ADDR_W-1:IDX_W];
        end else begin : g_no_oor
            assign oor = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept && oor) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    // Upper address bits are intentionally ignored: the index wraps
    // modulo DEPTH.
    generate
        if (ADDR_W > IDX_W) begin : g_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr[ADDR_W-1:IDX_W];
        end
    endgenerate

    assign oor = 1'b0;
    assign err = 1'b0;
`endif

    // ---- Stage p0: accept cycle, byte-masked write into the array ----
    always_ff @(posedge clk) begin
        if (accept && we && !oor) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[idx][i*8 +: 8] <= dbus[i*8 +: 8];
                end
            end
        end
    end

    // ---- Stage p1: read word captured at accept, held until RESP ----
    // The capture is taken at accept, so later addr/dbus activity cannot
    // disturb the response. A write one cycle earlier has already landed in
    // the array by this edge, so its bytes are returned.
    always_ff @(posedge clk) begin
        if (accept && !we) begin
            rdata_p1 <= oor ? '0 : mem[idx];
        end
    end

    // The block drives the bus only in the response cycle.
    assign dbus = rvalid ? rdata_p1 : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt_p0 <= 2'd0;
        end else begin
            state  <= state_nxt;
            cnt_p0 <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_p0;
        case (state)
            IDLE: begin
                if (en && !we) begin
                    if (READ_LAT == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_p0 == 2'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt_p0 - 2'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
